// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC weight loader: FSM states, beat geometry
// and the byte positions of each lane/sub-port inside a 64-bit weight beat.
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SET  = 2'd2,
      ST_DONE = 2'd3
   } loader_state_t;

   localparam int WEIGHT_BYTE_W = 8;
   localparam int MAC_LANES     = 4;
   localparam int WEIGHT_BEAT_W = 64;

   // Byte slot of each lane/sub-port within s_weight_data
   localparam int BYTE_A_0 = 0;
   localparam int BYTE_B_0 = 1;
   localparam int BYTE_C_0 = 2;
   localparam int BYTE_D_0 = 3;
   localparam int BYTE_A_1 = 4;
   localparam int BYTE_B_1 = 5;
   localparam int BYTE_C_1 = 6;
   localparam int BYTE_D_1 = 7;

   function automatic logic [WEIGHT_BYTE_W-1:0] beat_byte(
      input logic [WEIGHT_BEAT_W-1:0] beat,
      input int                       idx
   );
      return beat[idx*WEIGHT_BYTE_W +: WEIGHT_BYTE_W];
   endfunction

endpackage

// File: rtl/weight_beat_reg.sv
// Captures an accepted weight beat, 1-cycle latency; prepare_weight marks the cycle
// a fresh beat is presented, otherwise the bytes hold. No backpressure of its own.
module weight_beat_reg
   import mac_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic [WEIGHT_BEAT_W-1:0] beat_dat,
   output logic                     prepare_weight,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_a_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_b_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_c_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_d_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_a_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_b_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_c_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_d_1
);

   logic [WEIGHT_BEAT_W-1:0] beat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q         <= '0;
         prepare_weight <= 1'b0;
      end else begin
         prepare_weight <= load_en;
         if (load_en) begin
            beat_q <= beat_dat;
         end
      end
   end

   assign o_load_weight_data_a_0 = beat_byte(beat_q, BYTE_A_0);
   assign o_load_weight_data_b_0 = beat_byte(beat_q, BYTE_B_0);
   assign o_load_weight_data_c_0 = beat_byte(beat_q, BYTE_C_0);
   assign o_load_weight_data_d_0 = beat_byte(beat_q, BYTE_D_0);
   assign o_load_weight_data_a_1 = beat_byte(beat_q, BYTE_A_1);
   assign o_load_weight_data_b_1 = beat_byte(beat_q, BYTE_B_1);
   assign o_load_weight_data_c_1 = beat_byte(beat_q, BYTE_C_1);
   assign o_load_weight_data_d_1 = beat_byte(beat_q, BYTE_D_1);

endmodule

// File: rtl/mac_weight_loader.sv
// Streams NUM_ROWS weight beats into the MAC tile chain then pulses set_weight and done;
// data latency 1 cycle, ready is a pure state decode so a valid gap simply stalls the load.
module mac_weight_loader
   import mac_pkg::*;
#(
   parameter int NUM_ROWS  = 16,
   parameter int CNT_WIDTH = $clog2(NUM_ROWS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     s_weight_valid,
   output logic                     s_weight_ready,
   input  logic [WEIGHT_BEAT_W-1:0] s_weight_data,
   output logic                     prepare_weight,
   output logic                     set_weight,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_a_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_b_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_c_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_d_0,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_a_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_b_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_c_1,
   output logic [WEIGHT_BYTE_W-1:0] o_load_weight_data_d_1
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_ROWS - 1);

   loader_state_t          state, state_nxt;
   logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
   logic                   accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      s_weight_ready = 1'b0;
      set_weight     = 1'b0;
      done           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               cnt_nxt   = '0;
            end
         end
         ST_LOAD: begin
            s_weight_ready = 1'b1;
            if (s_weight_valid) begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
               if (cnt == LAST_CNT) begin
                  state_nxt = ST_SET;
               end
            end
         end
         ST_SET: begin
            // Coincides with the final beat's prepare_weight; the tiles order shift before latch
            set_weight = 1'b1;
            state_nxt  = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy   = (state != ST_IDLE);
   assign accept = s_weight_valid && s_weight_ready;

   weight_beat_reg u_beat_reg (
      .clk                    (clk),
      .rst                    (rst),
      .load_en                (accept),
      .beat_dat               (s_weight_data),
      .prepare_weight         (prepare_weight),
      .o_load_weight_data_a_0 (o_load_weight_data_a_0),
      .o_load_weight_data_b_0 (o_load_weight_data_b_0),
      .o_load_weight_data_c_0 (o_load_weight_data_c_0),
      .o_load_weight_data_d_0 (o_load_weight_data_d_0),
      .o_load_weight_data_a_1 (o_load_weight_data_a_1),
      .o_load_weight_data_b_1 (o_load_weight_data_b_1),
      .o_load_weight_data_c_1 (o_load_weight_data_c_1),
      .o_load_weight_data_d_1 (o_load_weight_data_d_1)
   );

endmodule

// File: tb/tb_mac_weight_loader.sv
// Bench for mac_weight_loader: a 4-row instance driven by vectors and hand sequences with a
// beat scoreboard, plus a 1-row instance for the single-beat case.
module tb_mac_weight_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, valid4, start1, valid1;
   logic [63:0] data4, data1;

   logic        busy4, done4, ready4, prep4, set4;
   logic [7:0]  a0_4, b0_4, c0_4, d0_4, a1_4, b1_4, c1_4, d1_4;
   logic        busy1, done1, ready1, prep1, set1;
   logic [7:0]  a0_1, b0_1, c0_1, d0_1, a1_1, b1_1, c1_1, d1_1;
   logic [63:0] out4, out1;

   int passed = 0;
   int total  = 0;
   int prep_cnt = 0;
   int set_cnt  = 0;
   int done_cnt = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   assign out4 = {d1_4, c1_4, b1_4, a1_4, d0_4, c0_4, b0_4, a0_4};
   assign out1 = {d1_1, c1_1, b1_1, a1_1, d0_1, c0_1, b0_1, a0_1};

   mac_weight_loader #(.NUM_ROWS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .s_weight_valid(valid4), .s_weight_ready(ready4), .s_weight_data(data4),
      .prepare_weight(prep4), .set_weight(set4),
      .o_load_weight_data_a_0(a0_4), .o_load_weight_data_b_0(b0_4),
      .o_load_weight_data_c_0(c0_4), .o_load_weight_data_d_0(d0_4),
      .o_load_weight_data_a_1(a1_4), .o_load_weight_data_b_1(b1_4),
      .o_load_weight_data_c_1(c1_4), .o_load_weight_data_d_1(d1_4)
   );

   mac_weight_loader #(.NUM_ROWS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .s_weight_valid(valid1), .s_weight_ready(ready1), .s_weight_data(data1),
      .prepare_weight(prep1), .set_weight(set1),
      .o_load_weight_data_a_0(a0_1), .o_load_weight_data_b_0(b0_1),
      .o_load_weight_data_c_0(c0_1), .o_load_weight_data_d_0(d0_1),
      .o_load_weight_data_a_1(a1_1), .o_load_weight_data_b_1(b1_1),
      .o_load_weight_data_c_1(c1_1), .o_load_weight_data_d_1(d1_1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic vld, input logic [63:0] dat);
      start4 = st;
      valid4 = vld;
      data4  = dat;
      tick();
   endtask

   // Beat that the bench knows lands while the loader is in LOAD
   task automatic beat(input logic [63:0] dat);
      sb.push_back(dat);
      drive(1'b0, 1'b1, dat);
   endtask

   task automatic clr_counts();
      prep_cnt = 0;
      set_cnt  = 0;
      done_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (prep4 === 1'b1) begin
         prep_cnt++;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_underflow: prepare_weight with no beat expected, data %h", out4);
         end else begin
            chk("beat_data", out4, sb.pop_front());
         end
      end
      if (set4 === 1'b1) set_cnt++;
      if (done4 === 1'b1) done_cnt++;
   end

   typedef struct {
      logic        start;
      logic        valid;
      logic [63:0] dat;
      logic        rdy;
      logic        prep;
      logic        set;
      logic        done;
      logic        busy;
      logic [7:0]  a0;
   } vec_t;

   vec_t vt[7];
   localparam logic [63:0] BASE = 64'h0807060504030201;

   initial begin
      vt[0] = '{1'b1, 1'b0, 64'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      vt[1] = '{1'b0, 1'b1, BASE+0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01};
      vt[2] = '{1'b0, 1'b1, BASE+1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
      vt[3] = '{1'b0, 1'b1, BASE+2,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03};
      vt[4] = '{1'b0, 1'b1, BASE+3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04};
      vt[5] = '{1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04};
      vt[6] = '{1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04};

      rst = 1'b1; start4 = 0; valid4 = 0; data4 = '0;
      start1 = 0; valid1 = 0; data1 = '0;
      tick(); tick();

      // Reset state and idle
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_out", {busy4, done4, ready4, prep4, set4}, 5'b0);
         chk("idle_data", out4, 64'd0);
      end

      // Back-to-back 4-beat load from the vector table
      clr_counts();
      for (int i = 0; i < 7; i++) begin
         if (vt[i].valid) sb.push_back(vt[i].dat);
         drive(vt[i].start, vt[i].valid, vt[i].dat);
         chk($sformatf("vec%0d_ctl", i), {ready4, prep4, set4, done4, busy4},
             {vt[i].rdy, vt[i].prep, vt[i].set, vt[i].done, vt[i].busy});
         chk($sformatf("vec%0d_a0", i), a0_4, vt[i].a0);
      end
      chk("t2_prep_cnt", prep_cnt, 4);
      chk("t2_set_cnt", set_cnt, 1);

      // Valid gap of 3 cycles after beat 2
      clr_counts();
      drive(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) beat(BASE + 64'(i));
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, '0);
         chk("gap_prep", prep4, 1'b0);
         chk("gap_hold", out4, BASE + 64'd2);
      end
      beat(BASE + 64'd3);
      chk("gap_set_with_last", {prep4, set4}, 2'b11);
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
      chk("gap_prep_cnt", prep_cnt, 4);
      chk("gap_set_cnt", set_cnt, 1);
      chk("gap_done_cnt", done_cnt, 1);

      // start while busy (LOAD and DONE) is ignored
      clr_counts();
      drive(1'b1, 1'b0, '0);
      sb.push_back(BASE);
      drive(1'b1, 1'b1, BASE);
      for (int i = 1; i < 4; i++) beat(BASE + 64'(i));
      drive(1'b0, 1'b0, '0);
      chk("busy_in_done", {busy4, done4}, 2'b11);
      drive(1'b1, 1'b0, '0);
      chk("start_in_done_ignored", busy4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, '0);
         chk("no_second_load", {busy4, ready4}, 2'b00);
      end
      chk("ign_prep_cnt", prep_cnt, 4);
      chk("ign_set_cnt", set_cnt, 1);

      // Reset mid-LOAD, reset vs start priority, then a clean reload
      clr_counts();
      drive(1'b1, 1'b0, '0);
      beat(BASE + 64'h10);
      beat(BASE + 64'h11);
      rst = 1'b1;
      drive(1'b0, 1'b1, BASE + 64'h12);
      chk("rst_ctl", {busy4, done4, ready4, prep4, set4}, 5'b0);
      chk("rst_data", out4, 64'd0);
      drive(1'b1, 1'b0, '0);
      chk("rst_beats_start", busy4, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b0, '0);
      chk("rst_stays_idle", busy4, 1'b0);
      drive(1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) beat(BASE + 64'h20 + 64'(i));
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
      chk("reload_busy", busy4, 1'b0);
      chk("rst_prep_cnt", prep_cnt, 6);
      chk("rst_set_cnt", set_cnt, 1);
      chk("rst_done_cnt", done_cnt, 1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      // Single-row instance: first accept goes straight to SET
      start1 = 1'b1;
      tick();
      chk("r1_ready", {ready1, busy1}, 2'b11);
      start1 = 1'b0; valid1 = 1'b1; data1 = 64'hFFEEDDCCBBAA9988;
      tick();
      chk("r1_prep_set", {prep1, set1, ready1}, 3'b110);
      chk("r1_a0", a0_1, 8'h88);
      chk("r1_d1", d1_1, 8'hFF);
      chk("r1_all", out1, 64'hFFEEDDCCBBAA9988);
      valid1 = 1'b0;
      tick();
      chk("r1_done", {done1, prep1, set1, busy1}, 4'b1001);
      tick();
      chk("r1_idle", {done1, busy1}, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
